joystick_spi_reader: RTL



---
 rtl/joystick_spi_reader.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/joystick_spi_reader.sv
// PmodJSTK poller: mode-0 SPI master that reads the 5-byte report and publishes X/Y/buttons plus a quantized X.
// Optional macro JOYSTICK_LED_EN adds the Leds input, which is sent in the first command byte.
module joystick_spi_reader #(
    parameter int CLK_DIV     = 50,
    parameter int BYTE_GAP    = 1500,
    parameter int POLL_PERIOD = 1000000
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       MISO,
`ifdef JOYSTICK_LED_EN
    input  logic [1:0] Leds,
`endif
    output logic       SS,
    output logic       SCLK,
    output logic       MOSI,
    output logic [3:0] Joystick_data,
    output logic [9:0] X_pos,
    output logic [9:0] Y_pos,
    output logic [2:0] Buttons,
    output logic       Sample_valid
);

    localparam int CNT_MAX = (BYTE_GAP > CLK_DIV) ? BYTE_GAP : CLK_DIV;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int POLL_W  = $clog2(POLL_PERIOD);
    localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(BYTE_GAP - 1);
    localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_PERIOD - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_GAP   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t              state_r, state_s;
    logic [CNT_W-1:0]    cnt_r, cnt_s;
    logic                phase_r, phase_s;
    logic [2:0]          bit_r, bit_s;
    logic [2:0]          byte_r, byte_s;
    logic [POLL_W-1:0]   poll_r;
    logic                tick_s;
    logic                sample_s;
    logic [39:0]         rx_r;
    logic                ss_s, sclk_s, mosi_s, tx_bit_s;
    logic [9:0]          x_new_s;

    // X*11 in a 14-bit product; the top four bits give the 0..10 code
    function automatic logic [3:0] quantize_x(input logic [9:0] x);
        logic [13:0] prod;
        prod = 14'(x) * 14'd11;
        return prod[13:10];
    endfunction

    assign tick_s   = (poll_r == POLL_LAST);
    assign sample_s = (state_r == ST_SHIFT) && (cnt_r == HALF_LAST) && !phase_r;
    assign x_new_s  = {rx_r[25:24], rx_r[39:32]};

    // Free-running poll counter
    always_ff @(posedge Clk) begin
        if (Reset) begin
            poll_r <= {POLL_W{1'b0}};
        end else if (tick_s) begin
            poll_r <= {POLL_W{1'b0}};
        end else begin
            poll_r <= poll_r + 1'b1;
        end
    end

    // FSM state and sequencing counters
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            phase_r <= 1'b0;
            bit_r   <= 3'd7;
            byte_r  <= 3'd0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            phase_r <= phase_s;
            bit_r   <= bit_s;
            byte_r  <= byte_s;
        end
    end

    // Next-state and counter sequencing
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r + 1'b1;
        phase_s = phase_r;
        bit_s   = bit_r;
        byte_s  = byte_r;
        case (state_r)
            ST_IDLE: begin
                cnt_s = {CNT_W{1'b0}};
                if (tick_s) begin
                    state_s = ST_SETUP;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (cnt_r == GAP_LAST) begin
                    state_s = ST_SHIFT;
                    cnt_s   = {CNT_W{1'b0}};
                    phase_s = 1'b0;
                    bit_s   = 3'd7;
                    byte_s  = 3'd0;
                end else begin
                    state_s = ST_SETUP;
                end
            end
            ST_SHIFT: begin
                if (cnt_r == HALF_LAST) begin
                    cnt_s = {CNT_W{1'b0}};
                    if (!phase_r) begin
                        phase_s = 1'b1;
                    end else begin
                        phase_s = 1'b0;
                        if (bit_r != 3'd0) begin
                            bit_s = bit_r - 3'd1;
                        end else if (byte_r < 3'd4) begin
                            state_s = ST_GAP;
                        end else begin
                            state_s = ST_DONE;
                        end
                    end
                end else begin
                    phase_s = phase_r;
                end
            end
            ST_GAP: begin
                if (cnt_r == GAP_LAST) begin
                    state_s = ST_SHIFT;
                    cnt_s   = {CNT_W{1'b0}};
                    bit_s   = 3'd7;
                    byte_s  = byte_r + 3'd1;
                end else begin
                    state_s = ST_GAP;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
                cnt_s   = {CNT_W{1'b0}};
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

`ifdef JOYSTICK_LED_EN
    logic [1:0] led_r;
    logic [7:0] tx_byte_s;

    // Capture Leds once per transaction, on the first SETUP cycle
    always_ff @(posedge Clk) begin
        if (Reset) begin
            led_r <= 2'b00;
        end else if ((state_r == ST_SETUP) && (cnt_r == {CNT_W{1'b0}})) begin
            led_r <= Leds;
        end else begin
            led_r <= led_r;
        end
    end

    assign tx_byte_s = (byte_s == 3'd0) ? {6'b100000, led_r} : 8'h00;
    assign tx_bit_s  = tx_byte_s[bit_s];
`else
    assign tx_bit_s = 1'b0;
`endif

    // Pin values for the coming cycle, derived from the next state so pins and state stay aligned
    always_comb begin
        ss_s   = 1'b1;
        sclk_s = 1'b0;
        mosi_s = 1'b0;
        case (state_s)
            ST_SETUP, ST_GAP: begin
                ss_s = 1'b0;
            end
            ST_SHIFT: begin
                ss_s   = 1'b0;
                sclk_s = phase_s;
                mosi_s = tx_bit_s;
            end
            default: begin
                ss_s = 1'b1;
            end
        endcase
    end

    // Registered pins, receive shifter and published sample
    always_ff @(posedge Clk) begin
        if (Reset) begin
            SS            <= 1'b1;
            SCLK          <= 1'b0;
            MOSI          <= 1'b0;
            rx_r          <= 40'd0;
            X_pos         <= 10'd512;
            Y_pos         <= 10'd512;
            Buttons       <= 3'd0;
            Joystick_data <= 4'd5;
            Sample_valid  <= 1'b0;
        end else begin
            SS           <= ss_s;
            SCLK         <= sclk_s;
            MOSI         <= mosi_s;
            Sample_valid <= (state_r == ST_DONE);
            if (sample_s) begin
                rx_r <= {rx_r[38:0], MISO};
            end else begin
                rx_r <= rx_r;
            end
            if (state_r == ST_DONE) begin
                X_pos         <= x_new_s;
                Y_pos         <= {rx_r[9:8], rx_r[23:16]};
                Buttons       <= rx_r[2:0];
                Joystick_data <= quantize_x(x_new_s);
            end else begin
                X_pos         <= X_pos;
                Y_pos         <= Y_pos;
                Buttons       <= Buttons;
                Joystick_data <= Joystick_data;
            end
        end
    end

endmodule
